// File: rtl/rr_mux4_arbiter_pkg.sv
// Shared types and the round-robin pick helper for the four-way packet arbiter.
package arb_pkg;

    localparam int NUM_REQ = 4;

    typedef logic [1:0] src_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // First set valid bit searched in order ptr+1, ptr+2, ptr+3, ptr (mod 4).
    // Returns ptr+1 when nothing is valid; callers qualify with the valid bit.
    function automatic src_t rr_pick(input logic [3:0] valid, input src_t ptr);
        src_t pick;
        src_t idx;
        pick = ptr + 2'd1;
        // Walk from lowest to highest priority so the highest priority hit wins.
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = ptr + src_t'(k);
            if (valid[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_mux4_arbiter_if.sv
// Bundle of the four requester channels and the single downstream channel.
interface rr_mux4_arbiter_if
    import arb_pkg::*;
#(
    parameter int N = 8
);
    logic [N-1:0] in_data_0;
    logic [N-1:0] in_data_1;
    logic [N-1:0] in_data_2;
    logic [N-1:0] in_data_3;
    logic [3:0]   in_valid;
    logic [3:0]   in_last;
    logic [3:0]   in_ready;
    logic [N-1:0] out_data;
    src_t         out_src;
    logic         out_last;
    logic         out_valid;
    logic         out_ready;
    logic         trunc_err;
    logic         busy;

    // Producers plus consumer side.
    modport master (
        output in_data_0, in_data_1, in_data_2, in_data_3,
        output in_valid, in_last, out_ready,
        input  in_ready, out_data, out_src, out_last, out_valid,
        input  trunc_err, busy
    );

    // Arbiter side.
    modport slave (
        input  in_data_0, in_data_1, in_data_2, in_data_3,
        input  in_valid, in_last, out_ready,
        output in_ready, out_data, out_src, out_last, out_valid,
        output trunc_err, busy
    );

endinterface

// File: rtl/rr_mux4_arbiter_mux4.sv
// Plain 4-to-1 N-bit data selector used as the shared datapath.
module mux4 #(
    parameter int N = 8
) (
    input  logic [N-1:0] d0,
    input  logic [N-1:0] d1,
    input  logic [N-1:0] d2,
    input  logic [N-1:0] d3,
    input  logic [1:0]   sel,
    output logic [N-1:0] y
);

    // Pure combinational selection, no state.
    always_comb begin
        unique case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end

endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin packet arbiter: grants one of four requesters, holds the grant
// until the packet's last beat (or a forced release after MAX_BEATS beats)
// and feeds the selected beat into a one-entry registered output stage.
module rr_mux4_arbiter
    import arb_pkg::*;
#(
    parameter int N         = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic               clk,
    input  logic               rst,
    rr_mux4_arbiter_if.slave   bus
);

    localparam int              CW       = $clog2(MAX_BEATS + 1);
    localparam logic [CW-1:0]   LAST_CNT = CW'(MAX_BEATS - 1);

    state_t         state_reg, state_next;
    src_t           ptr_reg, ptr_next;
    src_t           gnt_reg, gnt_next;
    logic [CW-1:0]  beat_cnt_reg, beat_cnt_next;

    logic [N-1:0]   out_data_reg, out_data_next;
    src_t           out_src_reg, out_src_next;
    logic           out_last_reg, out_last_next;
    logic           out_valid_reg, out_valid_next;
    logic           trunc_err_reg, trunc_err_next;

    src_t           winner;
    src_t           sel;
    logic           sel_valid;
    logic           out_free;
    logic           xfer;
    logic           cnt_at_limit;
    logic           eff_last;
    logic           forced_last;
    logic [N-1:0]   mux_data;

    // Shared datapath: the selected requester's data.
    mux4 #(.N(N)) u_mux4 (
        .d0  (bus.in_data_0),
        .d1  (bus.in_data_1),
        .d2  (bus.in_data_2),
        .d3  (bus.in_data_3),
        .sel (sel),
        .y   (mux_data)
    );

    // Arbitration and handshake decode; arbitration adds no cycle of latency.
    always_comb begin
        winner       = rr_pick(bus.in_valid, ptr_reg);
        sel          = (state_reg == IDLE) ? winner : gnt_reg;
        sel_valid    = bus.in_valid[sel];
        out_free     = !out_valid_reg || bus.out_ready;
        xfer         = sel_valid && out_free;
        cnt_at_limit = (beat_cnt_reg == LAST_CNT);
        eff_last     = bus.in_last[sel] || cnt_at_limit;
        forced_last  = cnt_at_limit && !bus.in_last[sel];
    end

    // One ready per requester; only the selected one can be high. Held low
    // during reset so nothing is accepted while the block is being cleared.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign bus.in_ready[gi] = !rst && xfer && (sel == src_t'(gi));
        end
    endgenerate

    // Next-state for the grant FSM, round-robin pointer and beat counter.
    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        gnt_next      = gnt_reg;
        beat_cnt_next = beat_cnt_reg;
        unique case (state_reg)
            IDLE: begin
                if (xfer) begin
                    if (eff_last) begin
                        ptr_next = winner;
                    end else begin
                        state_next    = LOCKED;
                        gnt_next      = winner;
                        beat_cnt_next = CW'(1);
                    end
                end
            end
            LOCKED: begin
                // A grant survives any number of idle cycles from its owner.
                if (xfer) begin
                    if (eff_last) begin
                        state_next    = IDLE;
                        ptr_next      = gnt_reg;
                        beat_cnt_next = '0;
                    end else begin
                        beat_cnt_next = beat_cnt_reg + CW'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Next-state for the one-entry output register and the truncation pulse.
    always_comb begin
        out_data_next  = out_data_reg;
        out_src_next   = out_src_reg;
        out_last_next  = out_last_reg;
        out_valid_next = out_valid_reg;
        trunc_err_next = 1'b0;
        if (xfer) begin
            out_data_next  = mux_data;
            out_src_next   = sel;
            out_last_next  = eff_last;
            out_valid_next = 1'b1;
            trunc_err_next = forced_last;
        end else if (bus.out_ready) begin
            out_valid_next = 1'b0;
        end
    end

    // Grant FSM, pointer and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            ptr_reg      <= 2'd3;
            gnt_reg      <= 2'd0;
            beat_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            gnt_reg      <= gnt_next;
            beat_cnt_reg <= beat_cnt_next;
        end
    end

    // Output stage registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data_reg  <= '0;
            out_src_reg   <= 2'd0;
            out_last_reg  <= 1'b0;
            out_valid_reg <= 1'b0;
            trunc_err_reg <= 1'b0;
        end else begin
            out_data_reg  <= out_data_next;
            out_src_reg   <= out_src_next;
            out_last_reg  <= out_last_next;
            out_valid_reg <= out_valid_next;
            trunc_err_reg <= trunc_err_next;
        end
    end

    assign bus.out_data  = out_data_reg;
    assign bus.out_src   = out_src_reg;
    assign bus.out_last  = out_last_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.trunc_err = trunc_err_reg;
    assign bus.busy      = (state_reg == LOCKED);

endmodule

// File: tb/tb_rr_mux4_arbiter.sv
// Bench for rr_mux4_arbiter: async reset check, a directed vector table,
// then randomized traffic against a behavioural model of the arbiter.
module tb_rr_mux4_arbiter;
    import arb_pkg::*;

    localparam int N    = 8;
    localparam int MAXB = 4;

    logic clk;
    logic rst;

    rr_mux4_arbiter_if #(.N(N)) bus ();

    rr_mux4_arbiter #(.N(N), .MAX_BEATS(MAXB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] last;
        logic [7:0] d0, d1, d2, d3;
        logic       ordy;
        logic [3:0] e_ready;
        logic       e_valid;
        logic [1:0] e_src;
        logic [7:0] e_data;
        logic       e_last;
        logic       e_trunc;
        logic       e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic [3:0] valid, input logic [3:0] last,
                       input logic [7:0] d0, input logic [7:0] d1,
                       input logic [7:0] d2, input logic [7:0] d3,
                       input logic ordy, input logic [3:0] e_ready,
                       input logic e_valid, input logic [1:0] e_src,
                       input logic [7:0] e_data, input logic e_last,
                       input logic e_trunc, input logic e_busy);
        vec_t v;
        v.valid = valid; v.last = last;
        v.d0 = d0; v.d1 = d1; v.d2 = d2; v.d3 = d3;
        v.ordy = ordy; v.e_ready = e_ready; v.e_valid = e_valid;
        v.e_src = e_src; v.e_data = e_data; v.e_last = e_last;
        v.e_trunc = e_trunc; v.e_busy = e_busy;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [3:0] valid, input logic [3:0] last,
                         input logic [7:0] d0, input logic [7:0] d1,
                         input logic [7:0] d2, input logic [7:0] d3,
                         input logic ordy);
        bus.in_valid  = valid;
        bus.in_last   = last;
        bus.in_data_0 = d0;
        bus.in_data_1 = d1;
        bus.in_data_2 = d2;
        bus.in_data_3 = d3;
        bus.out_ready = ordy;
    endtask

    // Behavioural model state: owner of the current packet (-1 = none),
    // round-robin pointer, beats taken in the current packet, output register.
    int         m_owner, m_ptr, m_cnt;
    logic       m_ov, m_ol, m_tr;
    logic [7:0] m_od;
    logic [1:0] m_os;
    int         n_beats;

    task automatic model_reset();
        m_owner = -1; m_ptr = 3; m_cnt = 0;
        m_ov = 1'b0; m_ol = 1'b0; m_tr = 1'b0; m_od = 8'h00; m_os = 2'd0;
    endtask

    task automatic rand_cycle(input int cyc);
        logic [7:0] dat [4];
        logic [3:0] valid, last, exp_ready;
        logic       ordy, free, fl, el;
        int         s, c, base;
        for (int i = 0; i < 4; i++) dat[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 4; i++) begin
            valid[i] = ($urandom_range(0, 9) < 6);
            last[i]  = ($urandom_range(0, 9) < 3);
        end
        ordy = ($urandom_range(0, 3) != 0);
        drive(valid, last, dat[0], dat[1], dat[2], dat[3], ordy);
        @(negedge clk);
        // Who may move a beat this cycle, from the rules alone.
        free = !m_ov || ordy;
        s = -1;
        if (m_owner < 0) begin
            for (int k = 1; k <= 4; k++) begin
                c = (m_ptr + k) % 4;
                if (s < 0 && valid[c]) s = c;
            end
        end else if (valid[m_owner]) begin
            s = m_owner;
        end
        if (!free) s = -1;
        exp_ready = (s < 0) ? 4'b0000 : 4'(1 << s);
        chk("rnd_ready", 32'(bus.in_ready), 32'(exp_ready));
        chk("rnd_out_valid", 32'(bus.out_valid), 32'(m_ov));
        chk("rnd_busy", 32'(bus.busy), 32'(m_owner >= 0));
        chk("rnd_trunc", 32'(bus.trunc_err), 32'(m_tr));
        if (m_ov) begin
            chk("rnd_out_data", 32'(bus.out_data), 32'(m_od));
            chk("rnd_out_src", 32'(bus.out_src), 32'(m_os));
            chk("rnd_out_last", 32'(bus.out_last), 32'(m_ol));
            if (ordy) begin
                n_beats++;
                $display("rnd cyc %0d: out beat src=%0d data=%02h last=%0d",
                         cyc, bus.out_src, bus.out_data, bus.out_last);
            end
        end
        // Advance the model by one clock.
        if (s >= 0) begin
            base = (m_owner < 0) ? 0 : m_cnt;
            fl = !last[s] && (base == MAXB - 1);
            el = last[s] || fl;
            m_ov = 1'b1; m_od = dat[s]; m_os = 2'(s); m_ol = el; m_tr = fl;
            if (el) begin
                m_owner = -1; m_ptr = s; m_cnt = 0;
            end else begin
                m_owner = s; m_cnt = base + 1;
            end
        end else begin
            m_tr = 1'b0;
            if (ordy) m_ov = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        rst = 1'b1;
        drive(4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset during a packet: start a packet on requester 2, then reset mid-cycle.
        drive(4'b0100, 4'b0000, 8'h00, 8'h00, 8'h55, 8'h00, 1'b1);
        @(posedge clk);
        #1;
        chk("pre_rst_busy", 32'(bus.busy), 32'(1));
        chk("pre_rst_out_valid", 32'(bus.out_valid), 32'(1));
        #2;
        rst = 1'b1;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_out_data", 32'(bus.out_data), 32'(0));
        chk("rst_out_src", 32'(bus.out_src), 32'(0));
        chk("rst_out_last", 32'(bus.out_last), 32'(0));
        chk("rst_trunc", 32'(bus.trunc_err), 32'(0));
        chk("rst_busy", 32'(bus.busy), 32'(0));
        chk("rst_in_ready", 32'(bus.in_ready), 32'(0));
        $display("async reset applied mid-cycle");
        drive(4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        //   valid    last     d0     d1     d2     d3     ordy  e_rdy   ev  src data   el tr by
        // single beat after reset
        add(4'b0001, 4'b0001, 8'hA0, 8'h00, 8'h00, 8'h00, 1'b1, 4'b0001, 0, 0, 8'h00, 0, 0, 0);
        // requester 3 alone, leaving ptr at 3
        add(4'b1000, 4'b1000, 8'h00, 8'h00, 8'h00, 8'd13, 1'b1, 4'b1000, 1, 0, 8'hA0, 1, 0, 0);
        // all four valid, single-beat packets: order 0,1,2,3,0
        add(4'b1111, 4'b1111, 8'd10, 8'd11, 8'd12, 8'd13, 1'b1, 4'b0001, 1, 3, 8'd13, 1, 0, 0);
        add(4'b1111, 4'b1111, 8'd10, 8'd11, 8'd12, 8'd13, 1'b1, 4'b0010, 1, 0, 8'd10, 1, 0, 0);
        add(4'b1111, 4'b1111, 8'd10, 8'd11, 8'd12, 8'd13, 1'b1, 4'b0100, 1, 1, 8'd11, 1, 0, 0);
        add(4'b1111, 4'b1111, 8'd10, 8'd11, 8'd12, 8'd13, 1'b1, 4'b1000, 1, 2, 8'd12, 1, 0, 0);
        add(4'b1111, 4'b1111, 8'd10, 8'd11, 8'd12, 8'd13, 1'b1, 4'b0001, 1, 3, 8'd13, 1, 0, 0);
        // requester 2 locks for C1,C2,(gap of 2),C3 while 0 and 3 wait
        add(4'b1101, 4'b1001, 8'd10, 8'h00, 8'hC1, 8'd13, 1'b1, 4'b0100, 1, 0, 8'd10, 1, 0, 0);
        add(4'b1101, 4'b1001, 8'd10, 8'h00, 8'hC2, 8'd13, 1'b1, 4'b0100, 1, 2, 8'hC1, 0, 0, 1);
        add(4'b1001, 4'b1001, 8'd10, 8'h00, 8'h00, 8'd13, 1'b1, 4'b0000, 1, 2, 8'hC2, 0, 0, 1);
        add(4'b1001, 4'b1001, 8'd10, 8'h00, 8'h00, 8'd13, 1'b1, 4'b0000, 0, 0, 8'h00, 0, 0, 1);
        add(4'b1101, 4'b1101, 8'd10, 8'h00, 8'hC3, 8'd13, 1'b1, 4'b0100, 0, 0, 8'h00, 0, 0, 1);
        add(4'b1001, 4'b1001, 8'd10, 8'h00, 8'h00, 8'd13, 1'b1, 4'b1000, 1, 2, 8'hC3, 1, 0, 0);
        add(4'b0001, 4'b0001, 8'd10, 8'h00, 8'h00, 8'h00, 1'b1, 4'b0001, 1, 3, 8'd13, 1, 0, 0);
        // backpressure: B1 held for 4 cycles, then B1 and B2 stream back to back
        add(4'b0010, 4'b0000, 8'h00, 8'hB1, 8'h00, 8'h00, 1'b1, 4'b0010, 1, 0, 8'd10, 1, 0, 0);
        add(4'b0010, 4'b0010, 8'h00, 8'hB2, 8'h00, 8'h00, 1'b0, 4'b0000, 1, 1, 8'hB1, 0, 0, 1);
        add(4'b0010, 4'b0010, 8'h00, 8'hB2, 8'h00, 8'h00, 1'b0, 4'b0000, 1, 1, 8'hB1, 0, 0, 1);
        add(4'b0010, 4'b0010, 8'h00, 8'hB2, 8'h00, 8'h00, 1'b0, 4'b0000, 1, 1, 8'hB1, 0, 0, 1);
        add(4'b0010, 4'b0010, 8'h00, 8'hB2, 8'h00, 8'h00, 1'b0, 4'b0000, 1, 1, 8'hB1, 0, 0, 1);
        add(4'b0010, 4'b0010, 8'h00, 8'hB2, 8'h00, 8'h00, 1'b1, 4'b0010, 1, 1, 8'hB1, 0, 0, 1);
        add(4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 4'b0000, 1, 1, 8'hB2, 1, 0, 0);
        add(4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 4'b0000, 0, 0, 8'h00, 0, 0, 0);
        // truncation: requester 1 streams with no last, 4th beat forced
        add(4'b0010, 4'b0000, 8'h00, 8'hD1, 8'h00, 8'h00, 1'b1, 4'b0010, 0, 0, 8'h00, 0, 0, 0);
        add(4'b0010, 4'b0000, 8'h00, 8'hD2, 8'h00, 8'h00, 1'b1, 4'b0010, 1, 1, 8'hD1, 0, 0, 1);
        add(4'b0010, 4'b0000, 8'h00, 8'hD3, 8'h00, 8'h00, 1'b1, 4'b0010, 1, 1, 8'hD2, 0, 0, 1);
        add(4'b0010, 4'b0000, 8'h00, 8'hD4, 8'h00, 8'h00, 1'b1, 4'b0010, 1, 1, 8'hD3, 0, 0, 1);
        // ptr is now 1: requester 0 beats requester 1
        add(4'b0011, 4'b0001, 8'hE0, 8'hD5, 8'h00, 8'h00, 1'b1, 4'b0001, 1, 1, 8'hD4, 1, 1, 0);
        add(4'b0010, 4'b0000, 8'h00, 8'hD5, 8'h00, 8'h00, 1'b1, 4'b0010, 1, 0, 8'hE0, 1, 0, 0);
        add(4'b0010, 4'b0010, 8'h00, 8'hD6, 8'h00, 8'h00, 1'b1, 4'b0010, 1, 1, 8'hD5, 0, 0, 1);
        add(4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 4'b0000, 1, 1, 8'hD6, 1, 0, 0);
        add(4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 4'b0000, 0, 0, 8'h00, 0, 0, 0);
        // requester 3 ends a packet while requester 0 raises valid: 0 wins next
        add(4'b1000, 4'b0000, 8'h00, 8'h00, 8'h00, 8'hF0, 1'b1, 4'b1000, 0, 0, 8'h00, 0, 0, 0);
        add(4'b1001, 4'b1001, 8'h60, 8'h00, 8'h00, 8'hF1, 1'b1, 4'b1000, 1, 3, 8'hF0, 0, 0, 1);
        add(4'b0001, 4'b0001, 8'h60, 8'h00, 8'h00, 8'h00, 1'b1, 4'b0001, 1, 3, 8'hF1, 1, 0, 0);
        add(4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 4'b0000, 1, 0, 8'h60, 1, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            drive(v.valid, v.last, v.d0, v.d1, v.d2, v.d3, v.ordy);
            @(negedge clk);
            chk($sformatf("v%0d_ready", i), 32'(bus.in_ready), 32'(v.e_ready));
            chk($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'(v.e_valid));
            chk($sformatf("v%0d_trunc", i), 32'(bus.trunc_err), 32'(v.e_trunc));
            chk($sformatf("v%0d_busy", i), 32'(bus.busy), 32'(v.e_busy));
            if (v.e_valid) begin
                chk($sformatf("v%0d_out_data", i), 32'(bus.out_data), 32'(v.e_data));
                chk($sformatf("v%0d_out_src", i), 32'(bus.out_src), 32'(v.e_src));
                chk($sformatf("v%0d_out_last", i), 32'(bus.out_last), 32'(v.e_last));
            end
            $display("vec %0d: valid=%b ready=%b out_valid=%0d src=%0d data=%02h last=%0d trunc=%0d busy=%0d",
                     i, v.valid, bus.in_ready, bus.out_valid, bus.out_src, bus.out_data,
                     bus.out_last, bus.trunc_err, bus.busy);
            @(posedge clk);
            #1;
        end

        // Randomized traffic against the model, from a clean reset.
        drive(4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        n_beats = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            rand_cycle(cyc);
        end
        $display("random phase: %0d output beats observed", n_beats);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
